// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use/branch/mul-div hazard detection, forwarding selects, stall counter
// All hazard outputs are combinational; only the mul/div busy counter and stall counter are registered.
module pipeline_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MD_LATENCY  = 4,
  parameter int MD_CNT_W    = 3,
  parameter int STALL_CNT_W = 16,
  parameter int BRANCH_IN_D = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   BranchD,
  input  logic                   MdStartD,
  input  logic                   MdReadD,
  input  logic [REG_AW-1:0]      RsD,
  input  logic [REG_AW-1:0]      RtD,
  input  logic [REG_AW-1:0]      RsE,
  input  logic [REG_AW-1:0]      RtE,
  input  logic [REG_AW-1:0]      WriteRegE,
  input  logic [REG_AW-1:0]      WriteRegM,
  input  logic [REG_AW-1:0]      WriteRegW,
  input  logic                   MemtoRegE,
  input  logic                   RegWriteE,
  input  logic                   MdStartE,
  input  logic                   MemtoRegM,
  input  logic                   RegWriteM,
  input  logic                   RegWriteW,
  output logic                   StallF,
  output logic                   StallD,
  output logic                   FlushE,
  output logic                   ForwardAD,
  output logic                   ForwardBD,
  output logic [1:0]             ForwardAE,
  output logic [1:0]             ForwardBE,
  output logic                   MdBusy,
  output logic [STALL_CNT_W-1:0] StallCount
);

  localparam logic BR_D = (BRANCH_IN_D != 0);

  logic [MD_CNT_W-1:0]    md_cnt_q, md_cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   md_busy;
  logic                   lwstall, branchstall, mdstall, stall;
  logic                   fwd_ad, fwd_bd;
  logic [1:0]             fwd_ae, fwd_be;

  // A register-0 source never matches, so r==0 short-circuits every compare.
  function automatic logic [1:0] e_fwd_sel(input logic [REG_AW-1:0] r);
    if (r != '0 && r == WriteRegM && RegWriteM)
      return 2'b10;
    else if (r != '0 && r == WriteRegW && RegWriteW)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  function automatic logic d_src_hit(input logic [REG_AW-1:0] w);
    return (w != '0) && (w == RsD || w == RtD);
  endfunction

  assign md_busy = (md_cnt_q != '0);

  always_comb begin
    lwstall     = MemtoRegE && (RtE != '0) && (RtE == RsD || RtE == RtD);
    branchstall = BR_D && BranchD &&
                  ((RegWriteE && d_src_hit(WriteRegE)) ||
                   (MemtoRegM && d_src_hit(WriteRegM)));
    mdstall     = (MdReadD || MdStartD) && (md_busy || MdStartE);
    stall       = lwstall || branchstall || mdstall;
    fwd_ad      = BR_D && (RsD != '0) && (RsD == WriteRegM) && RegWriteM;
    fwd_bd      = BR_D && (RtD != '0) && (RtD == WriteRegM) && RegWriteM;
    fwd_ae      = e_fwd_sel(RsE);
    fwd_be      = e_fwd_sel(RtE);
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (MdStartE)
      md_cnt_d = MD_CNT_W'(MD_LATENCY);
    else if (md_busy)
      md_cnt_d = md_cnt_q - 1'b1;

    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // While reset is held every output reads 0, even mid-operation.
  assign StallF     = reset_n && stall;
  assign StallD     = reset_n && stall;
  assign FlushE     = reset_n && stall;
  assign ForwardAD  = reset_n && fwd_ad;
  assign ForwardBD  = reset_n && fwd_bd;
  assign ForwardAE  = reset_n ? fwd_ae : 2'b00;
  assign ForwardBE  = reset_n ? fwd_be : 2'b00;
  assign MdBusy     = reset_n && md_busy;
  assign StallCount = reset_n ? stall_cnt_q : '0;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed bench for pipeline_hazard_ctrl
// u0 default, u1 with branches resolved outside Decode, u2 with a 4-bit stall counter.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       BranchD, MdStartD, MdReadD;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       MemtoRegE, RegWriteE, MdStartE, MemtoRegM, RegWriteM, RegWriteW;

  logic       stf0, std0, fle0, fad0, fbd0, mdb0;
  logic [1:0] fae0, fbe0;
  logic [15:0] sc0;
  logic       stf1, std1, fle1, fad1, fbd1, mdb1;
  logic [1:0] fae1, fbe1;
  logic [15:0] sc1;
  logic       stf2, std2, fle2, fad2, fbd2, mdb2;
  logic [1:0] fae2, fbe2;
  logic [3:0] sc2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl u0 (
    .clk(clk), .reset_n(reset_n), .BranchD(BranchD), .MdStartD(MdStartD), .MdReadD(MdReadD),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE), .MdStartE(MdStartE),
    .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .StallF(stf0), .StallD(std0), .FlushE(fle0), .ForwardAD(fad0), .ForwardBD(fbd0),
    .ForwardAE(fae0), .ForwardBE(fbe0), .MdBusy(mdb0), .StallCount(sc0)
  );

  pipeline_hazard_ctrl #(.BRANCH_IN_D(0)) u1 (
    .clk(clk), .reset_n(reset_n), .BranchD(BranchD), .MdStartD(MdStartD), .MdReadD(MdReadD),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE), .MdStartE(MdStartE),
    .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .StallF(stf1), .StallD(std1), .FlushE(fle1), .ForwardAD(fad1), .ForwardBD(fbd1),
    .ForwardAE(fae1), .ForwardBE(fbe1), .MdBusy(mdb1), .StallCount(sc1)
  );

  pipeline_hazard_ctrl #(.STALL_CNT_W(4)) u2 (
    .clk(clk), .reset_n(reset_n), .BranchD(BranchD), .MdStartD(MdStartD), .MdReadD(MdReadD),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE), .MdStartE(MdStartE),
    .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .StallF(stf2), .StallD(std2), .FlushE(fle2), .ForwardAD(fad2), .ForwardBD(fbd2),
    .ForwardAE(fae2), .ForwardBE(fbe2), .MdBusy(mdb2), .StallCount(sc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs u0's single-bit outputs: {StallF,StallD,FlushE,ForwardAD,ForwardBD,MdBusy}
  function automatic logic [31:0] bits0();
    return {26'd0, stf0, std0, fle0, fad0, fbd0, mdb0};
  endfunction

  task automatic clear_inputs();
    BranchD = 0; MdStartD = 0; MdReadD = 0;
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    MemtoRegE = 0; RegWriteE = 0; MdStartE = 0;
    MemtoRegM = 0; RegWriteM = 0; RegWriteW = 0;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    reset_n = 0;
    adv(); adv();

    // Reset state, with a load-use and forward pattern present that must be masked.
    MemtoRegE = 1; RtE = 8; RsD = 8; RsE = 3; WriteRegM = 3; RegWriteM = 1;
    settle();
    chk("rst_bits", bits0(), 32'h0);
    chk("rst_fae", {30'd0, fae0}, 32'h0);
    chk("rst_sc", {16'd0, sc0}, 32'h0);
    adv();
    clear_inputs();
    reset_n = 1;

    // Load-use stall
    MemtoRegE = 1; RtE = 8; RsD = 8;
    settle();
    chk("lu_stall", bits0(), 32'b111000);
    chk("lu_stall_u1", {31'd0, std1}, 32'h1);
    adv();
    // Consumer now in E, producer in W
    clear_inputs();
    WriteRegW = 8; RegWriteW = 1; RsE = 8;
    settle();
    chk("lu_fwd_ae", {30'd0, fae0}, 32'h1);
    chk("lu_fwd_be", {30'd0, fbe0}, 32'h0);
    chk("lu_nostall", {31'd0, std0}, 32'h0);
    chk("lu_sc", {16'd0, sc0}, 32'd1);
    adv();

    // Forward priority M over W
    clear_inputs();
    RsE = 3; RtE = 3; WriteRegM = 3; WriteRegW = 3; RegWriteM = 1; RegWriteW = 1;
    settle();
    chk("prio_ae", {30'd0, fae0}, 32'h2);
    chk("prio_be", {30'd0, fbe0}, 32'h2);
    adv();
    // Register 0 is never a hazard source
    RsE = 0; RtE = 0; WriteRegM = 0; WriteRegW = 0; MemtoRegE = 1; RsD = 0; RtD = 0;
    RegWriteE = 1; WriteRegE = 0; BranchD = 1;
    settle();
    chk("r0_ae", {30'd0, fae0}, 32'h0);
    chk("r0_be", {30'd0, fbe0}, 32'h0);
    chk("r0_bits", bits0(), 32'h0);
    adv();

    // Branch depending on ALU result in E
    clear_inputs();
    BranchD = 1; RsD = 5; RegWriteE = 1; WriteRegE = 5;
    settle();
    chk("br_e_stall", {31'd0, std0}, 32'h1);
    chk("br_e_stall_u1", {31'd0, std1}, 32'h0);
    adv();
    // Producer moved to M: forward instead of stall
    RegWriteE = 0; WriteRegE = 0; WriteRegM = 5; RegWriteM = 1; MemtoRegM = 0;
    settle();
    chk("br_m_bits", bits0(), 32'b000100);
    chk("br_m_u1_ad", {31'd0, fad1}, 32'h0);
    chk("br_m_u1_stall", {31'd0, std1}, 32'h0);
    adv();
    // Load still in M: branch must stall (uses Rt side)
    RsD = 0; RtD = 5; MemtoRegM = 1;
    settle();
    chk("br_ld_bits", bits0(), 32'b111010);
    chk("br_ld_u1", {30'd0, std1, fbd1}, 32'h0);
    adv();

    // Mul/div start at t with MdReadD held
    clear_inputs();
    MdReadD = 1; MdStartE = 1;
    settle();
    chk("md_t_stall", {31'd0, std0}, 32'h1);
    chk("md_t_busy", {31'd0, mdb0}, 32'h0);
    adv();
    MdStartE = 0;
    for (int k = 1; k <= 4; k++) begin
      settle();
      chk($sformatf("md_t%0d_stall", k), {31'd0, std0}, 32'h1);
      chk($sformatf("md_t%0d_busy", k), {31'd0, mdb0}, 32'h1);
      adv();
    end
    settle();
    chk("md_t5_stall", {31'd0, std0}, 32'h0);
    chk("md_t5_busy", {31'd0, mdb0}, 32'h0);
    chk("md_sc_u0", {16'd0, sc0}, 32'd8);
    chk("md_sc_u1", {16'd0, sc1}, 32'd6);
    chk("md_sc_u2", {28'd0, sc2}, 32'd8);
    adv();

    // Reset in the middle of a mul/div
    clear_inputs();
    MdStartE = 1;
    adv();
    MdStartE = 0;
    adv();
    reset_n = 0; MdReadD = 1;
    settle();
    chk("mrst_bits", bits0(), 32'h0);
    chk("mrst_sc", {16'd0, sc0}, 32'h0);
    adv();
    settle();
    chk("mrst2_bits", bits0(), 32'h0);
    adv();
    reset_n = 1;
    settle();
    chk("post_rst_bits", bits0(), 32'h0);
    chk("post_rst_sc", {16'd0, sc0}, 32'h0);
    adv();

    // Stall counter saturation on the 4-bit instance
    clear_inputs();
    MemtoRegE = 1; RtE = 8; RtD = 8;
    for (int k = 0; k < 14; k++) adv();
    settle();
    chk("sat_14", {28'd0, sc2}, 32'd14);
    adv();
    for (int k = 0; k < 5; k++) adv();
    settle();
    chk("sat_20_u2", {28'd0, sc2}, 32'd15);
    chk("sat_20_u0", {16'd0, sc0}, 32'd20);
    chk("sat_stall_still", {31'd0, std2}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
